// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the 16x16 sequential multiplier.
package mult_seq_pkg;

  localparam int unsigned ACC_W  = 32;
  localparam int unsigned SH_PP0 = 0;
  localparam int unsigned SH_PP1 = 8;
  localparam int unsigned SH_PP2 = 8;
  localparam int unsigned SH_PP3 = 16;

  typedef enum logic [2:0] {
    StIdle,
    StPp0,
    StPp1,
    StPp2,
    StPp3,
    StDone
  } state_e;

endpackage

// File: rtl/mult16_sequencer_if.sv
// Request/result handshake bundle for mult16_sequencer.
interface mult16_sequencer_if #(
  parameter int unsigned OPW = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [OPW-1:0]   a;
  logic [OPW-1:0]   b;
  logic             out_valid;
  logic             out_ready;
  logic [2*OPW-1:0] p;
  logic             busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, p, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, p, busy
  );

endinterface

// File: rtl/Multiplier8x8.sv
// Existing combinational 8x8 -> 16 unsigned multiplier, reused as-is.
module Multiplier8x8 (
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic [15:0] P
);

  assign P = {8'h00, A} * {8'h00, B};

endmodule

// File: rtl/mult16_sequencer.sv
// 16x16 -> 32 unsigned multiply over four 8x8 partial-product cycles.
// Optional SKIP_ZERO_PP_EN skips partial products whose high operand byte is zero.
module mult16_sequencer
  import mult_seq_pkg::*;
#(
  parameter int unsigned OPW              = 16,
  parameter bit          ACCEPT_WHEN_DONE = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  mult16_sequencer_if.slave bus
);

  state_e           state_q, state_d;
  logic [OPW-1:0]   a_q, a_d, b_q, b_d;
  logic [ACC_W-1:0] acc_q, acc_d, p_q, p_d, partial;
  logic             out_valid_q, out_valid_d, busy_q, busy_d;
  logic             accept;
  logic [7:0]       mul_a, mul_b;
  logic [15:0]      mul_p;
  logic [4:0]       shamt;
  state_e           nxt_pp0, nxt_pp1, nxt_pp2;
`ifdef SKIP_ZERO_PP_EN
  logic             a_hi_zero_q, a_hi_zero_d, b_hi_zero_q, b_hi_zero_d;
`endif

  // Gated by rst_n so nothing is accepted while reset is held.
  assign bus.in_ready = rst_n & ((state_q == StIdle) |
                                 (ACCEPT_WHEN_DONE & (state_q == StDone) & bus.out_ready));
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.p         = p_q;

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    shamt = '0;
    unique case (state_q)
      StPp0:   begin mul_a = a_q[7:0];  mul_b = b_q[7:0];  shamt = 5'(SH_PP0); end
      StPp1:   begin mul_a = a_q[15:8]; mul_b = b_q[7:0];  shamt = 5'(SH_PP1); end
      StPp2:   begin mul_a = a_q[7:0];  mul_b = b_q[15:8]; shamt = 5'(SH_PP2); end
      StPp3:   begin mul_a = a_q[15:8]; mul_b = b_q[15:8]; shamt = 5'(SH_PP3); end
      default: ;
    endcase
  end

  Multiplier8x8 u_mul (
    .A(mul_a),
    .B(mul_b),
    .P(mul_p)
  );

  assign partial = {16'h0000, mul_p} << shamt;

  always_comb begin
`ifdef SKIP_ZERO_PP_EN
    nxt_pp0 = !a_hi_zero_q ? StPp1 : (!b_hi_zero_q ? StPp2 : StDone);
    nxt_pp1 = b_hi_zero_q ? StDone : StPp2;
    nxt_pp2 = a_hi_zero_q ? StDone : StPp3;
`else
    nxt_pp0 = StPp1;
    nxt_pp1 = StPp2;
    nxt_pp2 = StPp3;
`endif
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    p_d     = p_q;
`ifdef SKIP_ZERO_PP_EN
    a_hi_zero_d = a_hi_zero_q;
    b_hi_zero_d = b_hi_zero_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          a_d     = bus.a;
          b_d     = bus.b;
          acc_d   = '0;
          state_d = StPp0;
`ifdef SKIP_ZERO_PP_EN
          a_hi_zero_d = (bus.a[15:8] == 8'h00);
          b_hi_zero_d = (bus.b[15:8] == 8'h00);
`endif
        end else if (state_q == StDone && bus.out_ready) begin
          state_d = StIdle;
        end
      end
      StPp0: begin acc_d = acc_q + partial; state_d = nxt_pp0; end
      StPp1: begin acc_d = acc_q + partial; state_d = nxt_pp1; end
      StPp2: begin acc_d = acc_q + partial; state_d = nxt_pp2; end
      StPp3: begin acc_d = acc_q + partial; state_d = StDone;  end
      default: state_d = StIdle;
    endcase
    // Publish the product only on entry to DONE so p stays put while held.
    if (state_d == StDone && state_q != StDone) p_d = acc_d;
    out_valid_d = (state_d == StDone);
    busy_d      = (state_d == StPp0) || (state_d == StPp1) ||
                  (state_d == StPp2) || (state_d == StPp3);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SKIP_ZERO_PP_EN
      a_hi_zero_q <= 1'b0;
      b_hi_zero_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef SKIP_ZERO_PP_EN
      a_hi_zero_q <= a_hi_zero_d;
      b_hi_zero_q <= b_hi_zero_d;
`endif
    end
  end

endmodule
